// File: rtl/step_pkg.sv
// ---------------------------------------------------------------------------
// step_pkg
// Shared types and constants for the single-step pulse generator.
//   key_state_e   : debounce FSM states
//   KEY_SYNC_RST  : reset value of the key synchronizer (released)
//   AUTO_SYNC_RST : reset value of the auto_mode synchronizer (off)
//   CNT_W         : width of the debounce counter and auto-run divider
//                   (covers the full 2..65535 parameter range)
// ---------------------------------------------------------------------------
package step_pkg;

  typedef enum logic [1:0] {
    S_UP      = 2'd0,
    S_DN_WAIT = 2'd1,
    S_DOWN    = 2'd2,
    S_UP_WAIT = 2'd3
  } key_state_e;

  localparam logic KEY_SYNC_RST  = 1'b1;
  localparam logic AUTO_SYNC_RST = 1'b0;

  localparam int CNT_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level input.
//   clk    : destination clock
//   resetn : asynchronous active-low reset, loads RST_VAL into both flops
//   d      : asynchronous input
//   q      : synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its source; = here would collapse the two stages.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// ---------------------------------------------------------------------------
// step_pulse_gen
// Turns a bouncy pushbutton into exactly one clean single-cycle step pulse
// per press, and keeps a running count of steps for display.
//
// Parameters
//   DEBOUNCE_CYCLES : stable synchronized samples needed to accept a change
//   AUTO_DIV        : auto-run step period in clk cycles
//
// Ports
//   clk        : sole clock
//   resetn     : asynchronous active-low reset
//   key_n      : raw pushbutton, asynchronous, 0 = pressed
//   auto_mode  : switch, asynchronous, 1 = free-running steps
//   step       : registered one-cycle step pulse
//   pressed    : registered debounced key level, 1 = pressed
//   step_count : registered count of step pulses issued (wraps at 255)
//
// Build option
//   STEP_PULSE_GEN_AUTORUN_EN : when defined, synced auto_mode = 1 replaces
//   manual steps with one pulse every AUTO_DIV cycles. When undefined,
//   auto_mode is ignored and only manual steps exist.
// ---------------------------------------------------------------------------
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_DIV        = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_n,
  input  logic       auto_mode,
  output logic       step,
  output logic       pressed,
  output logic [7:0] step_count
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             manual_step;
  logic             pressed_d;
  logic             step_d;

  sync_2ff #(.RST_VAL(KEY_SYNC_RST)) u_key_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (key_n),
    .q      (key_s)
  );

  // Debounce FSM. A change is accepted only after the synced key holds its
  // new level for DEBOUNCE_CYCLES consecutive samples; any reversion while
  // waiting drops straight back to the previous stable state.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    manual_step = 1'b0;
    case (state_q)
      S_UP: begin
        if (!key_s) begin
          state_d = S_DN_WAIT;
          cnt_d   = '0;
        end
      end
      S_DN_WAIT: begin
        if (key_s) begin
          state_d = S_UP;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = S_DOWN;
          manual_step = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DOWN: begin
        if (key_s) begin
          state_d = S_UP_WAIT;
          cnt_d   = '0;
        end
      end
      S_UP_WAIT: begin
        if (!key_s) begin
          state_d = S_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_UP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_UP;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered from the next state so pressed lines up with the state.
  assign pressed_d = (state_d == S_DOWN) || (state_d == S_UP_WAIT);

`ifdef STEP_PULSE_GEN_AUTORUN_EN
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(AUTO_DIV - 1);

  logic             auto_s;
  logic [CNT_W-1:0] div_q, div_d;
  logic             auto_pulse;

  sync_2ff #(.RST_VAL(AUTO_SYNC_RST)) u_auto_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (auto_mode),
    .q      (auto_s)
  );

  // Divider runs 0..AUTO_DIV-1 while auto-run is on and sits at 0 while
  // off, so re-enabling always waits a full period before the first step.
  always_comb begin
    auto_pulse = 1'b0;
    div_d      = '0;
    if (auto_s) begin
      if (div_q == DIV_LAST) begin
        auto_pulse = 1'b1;
      end else begin
        div_d = div_q + CNT_W'(1);
      end
    end
    // Masking with the current pulse keeps a mode switch from producing
    // two back-to-back steps.
    step_d = (auto_s ? auto_pulse : manual_step) & ~step;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  logic unused_auto_mode;
  assign unused_auto_mode = auto_mode;
  assign step_d           = manual_step & ~step;
`endif

  // NOTE: every flop here sits on the async reset; there is no memory array,
  // so nothing is left to come up undefined.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_UP;
      cnt_q      <= '0;
      step       <= 1'b0;
      pressed    <= 1'b0;
      step_count <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step    <= step_d;
      pressed <= pressed_d;
      if (step_d) begin
        step_count <= step_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_step_pulse_gen
// Self-checking bench for step_pulse_gen (DEBOUNCE_CYCLES=4, AUTO_DIV=4).
// Key patterns come from a table; each pattern pushes the clk edge at which
// a step is due onto a queue, and a negedge monitor pops and compares every
// step pulse the DUT emits. Reset, wrap and auto-run are hand-written.
// ---------------------------------------------------------------------------
module tb_step_pulse_gen;

  localparam int D = 4;
  localparam int A = 4;

  logic       clk;
  logic       resetn;
  logic       key_n;
  logic       auto_mode;
  logic       step;
  logic       pressed;
  logic [7:0] step_count;

  int checks;
  int failures;
  int cyc;
  int exp_q[$];
  int model_count;
  bit prev_step;

  typedef struct {
    int low1;
    int high1;
    int low2;
    int tail;
    bit exp_pressed;
  } vec_t;

  vec_t vecs[6];

  step_pulse_gen #(.DEBOUNCE_CYCLES(D), .AUTO_DIV(A)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .key_n      (key_n),
    .auto_mode  (auto_mode),
    .step       (step),
    .pressed    (pressed),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index: after posedge n, cyc == n when sampled on the negedge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic expect_step(input int edge_no);
    exp_q.push_back(edge_no);
    model_count = (model_count + 1) % 256;
  endtask

  // Scoreboard consumer: every step pulse must match the next expected edge.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (exp_q.size() == 0) check("step_unexpected", 1, 0);
      else                   check("step_edge", cyc, exp_q.pop_front());
      check("step_back_to_back", int'(prev_step), 0);
    end
    prev_step = (step === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Applies one table entry and checks pressed, step count and that every
  // expected step was seen.
  task automatic run_vec(input vec_t v);
    int s;
    s     = cyc + 1;
    key_n = 1'b0;
    if (v.low1 >= D + 1) expect_step(s + D + 2);
    wait_cycles(v.low1);
    if (v.low2 > 0) begin
      key_n = 1'b1;
      wait_cycles(v.high1);
      s     = cyc + 1;
      key_n = 1'b0;
      if (v.low2 >= D + 1 && v.low1 < D + 1) expect_step(s + D + 2);
      wait_cycles(v.low2);
    end
    key_n = 1'b1;
    wait_cycles(3);
    check("pressed_after_press", int'(pressed), int'(v.exp_pressed));
    wait_cycles(v.tail - 3);
    check("pressed_idle", int'(pressed), 0);
    check("missed_steps", exp_q.size(), 0);
    check("step_count", int'(step_count), model_count);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear without an edge.
  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst_step", int'(step), 0);
    check("rst_pressed", int'(pressed), 0);
    check("rst_step_count", int'(step_count), 0);
    exp_q.delete();
    model_count = 0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int s;
    checks      = 0;
    failures    = 0;
    model_count = 0;
    prev_step   = 1'b0;
    resetn      = 1'b0;
    key_n       = 1'b1;
    auto_mode   = 1'b0;

    vecs[0] = '{low1: 20, high1: 0, low2: 0, tail: 12, exp_pressed: 1'b1};
    vecs[1] = '{low1: 5,  high1: 0, low2: 0, tail: 12, exp_pressed: 1'b1};
    vecs[2] = '{low1: 4,  high1: 0, low2: 0, tail: 12, exp_pressed: 1'b0};
    vecs[3] = '{low1: 2,  high1: 2, low2: 2, tail: 12, exp_pressed: 1'b0};
    vecs[4] = '{low1: 3,  high1: 1, low2: 8, tail: 12, exp_pressed: 1'b1};
    vecs[5] = '{low1: 7,  high1: 1, low2: 7, tail: 12, exp_pressed: 1'b1};

    // Power-on reset, then 50 idle cycles with the key released.
    #2;
    check("por_step", int'(step), 0);
    check("por_pressed", int'(pressed), 0);
    check("por_step_count", int'(step_count), 0);
    @(negedge clk);
    resetn = 1'b1;
    wait_cycles(50);
    check("idle_pressed", int'(pressed), 0);
    check("idle_step_count", int'(step_count), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while debouncing: key held, in S_DN_WAIT, then reset.
    key_n = 1'b0;
    wait_cycles(4);
    do_reset();
    s = cyc + 1;
    expect_step(s + D + 2);
    wait_cycles(10);
    check("rst_dnwait_pressed", int'(pressed), 1);
    check("rst_dnwait_count", int'(step_count), 1);

    // Reset while pressed (S_DOWN), key still held through release.
    do_reset();
    s = cyc + 1;
    expect_step(s + D + 2);
    wait_cycles(10);
    key_n = 1'b1;
    wait_cycles(12);
    check("rst_down_missed", exp_q.size(), 0);
    check("rst_down_count", int'(step_count), 1);
    check("rst_down_pressed", int'(pressed), 0);

`ifdef STEP_PULSE_GEN_AUTORUN_EN
    // 42 cycles of auto-run: pulses every A cycles, a manual press inside.
    s         = cyc + 1;
    auto_mode = 1'b1;
    for (int e = s + A + 1; e <= s + 42 + 1; e += A) expect_step(e);
    wait_cycles(10);
    key_n = 1'b0;
    wait_cycles(8);
    check("auto_pressed_tracks", int'(pressed), 1);
    key_n = 1'b1;
    wait_cycles(24);
    auto_mode = 1'b0;
    wait_cycles(12);
    check("auto_missed", exp_q.size(), 0);
    check("auto_count", int'(step_count), model_count);
    check("auto_pressed_idle", int'(pressed), 0);

    // Re-enable: the divider was cleared, so a full period before step one.
    s         = cyc + 1;
    auto_mode = 1'b1;
    expect_step(s + A + 1);
    expect_step(s + 2 * A + 1);
    wait_cycles(10);
    auto_mode = 1'b0;
    wait_cycles(10);
    check("auto_rearm_missed", exp_q.size(), 0);
    check("auto_rearm_count", int'(step_count), model_count);
`else
    // Without auto-run support the switch must have no effect.
    auto_mode = 1'b1;
    wait_cycles(40);
    auto_mode = 1'b0;
    wait_cycles(4);
    check("auto_ignored_count", int'(step_count), model_count);
`endif

    // Wrap: 255 clean presses from zero, then one more.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      run_vec('{low1: 6, high1: 0, low2: 0, tail: 10, exp_pressed: 1'b1});
    end
    check("count_255", int'(step_count), 255);
    run_vec('{low1: 6, high1: 0, low2: 0, tail: 10, exp_pressed: 1'b1});
    check("count_wrap", int'(step_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a key change; legal range 2..65535.
REQ-002 SHALL have parameter AUTO_DIV, default 4: auto-run step period in clk cycles; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_n  input  1  raw pushbutton, asynchronous to clk; 0 = pressed.
REQ-006 SHALL have port auto_mode  input  1  1 = free-running steps (switch input, asynchronous to clk).
REQ-007 SHALL have port step  output  1  registered one-cycle pulse; the CPU advances one step per pulse.
REQ-008 SHALL have port pressed  output  1  registered debounced key level; 1 = pressed.
REQ-009 SHALL have port step_count  output  8  registered count of step pulses issued, for LEDR/HEX display.

Function
REQ-010 SHALL pass key_n and auto_mode through two-flop synchronizers before any use; the key synchronizer resets to 1 (released).
REQ-011 SHALL implement FSM states S_UP, S_DN_WAIT, S_DOWN, S_UP_WAIT with a debounce counter.
REQ-012 S_UP: synced key 0 -> S_DN_WAIT with counter cleared; otherwise hold.
REQ-013 S_DN_WAIT: synced key 1 -> S_UP with counter cleared; synced key 0 with counter = DEBOUNCE_CYCLES-1 -> S_DOWN; otherwise increment counter.
REQ-014 S_DOWN: synced key 1 -> S_UP_WAIT with counter cleared; otherwise hold.
REQ-015 S_UP_WAIT: synced key 0 -> S_DOWN with counter cleared; synced key 1 with counter = DEBOUNCE_CYCLES-1 -> S_UP; otherwise increment counter.
REQ-016 pressed SHALL be 1 exactly while state is S_DOWN or S_UP_WAIT.
REQ-017 Manual step SHALL be high for exactly one cycle, on the edge that takes S_DN_WAIT -> S_DOWN; latency: if key_n is first sampled low at edge 0, step is high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3.
REQ-018 A bounce (synced key returning to 1 in S_DN_WAIT) SHALL produce no step; a press held indefinitely SHALL produce exactly one step.
REQ-019 step_count SHALL increment by 1 on every cycle step is high and wrap from 255 to 0.
REQ-020 step SHALL never be high on two consecutive cycles.

Reset
REQ-021 On resetn low, state SHALL be S_UP, counter 0, synchronizers 1 (key) / 0 (auto), step 0, pressed 0, step_count 0, auto divider 0, immediately and without a clk edge.
REQ-022 Reset mid-debounce or mid-press SHALL discard all progress; a key held through reset release SHALL be debounced afresh and yield one step per REQ-017.

Configuration
REQ-023 Macro STEP_PULSE_GEN_AUTORUN_EN SHALL control auto-run mode.
REQ-024 With the macro defined and synced auto_mode = 1: the divider counts 0..AUTO_DIV-1, step is high for one cycle each time the divider wraps (one pulse per AUTO_DIV cycles), and manual presses produce no step while pressed still tracks the key.
REQ-025 With the macro defined: when synced auto_mode goes 0 the divider is cleared; on return to 1 the first auto step occurs AUTO_DIV cycles later.
REQ-026 Without the macro: auto_mode is ignored, no divider logic exists, and only manual steps occur.

Structure
REQ-027 Package step_pkg SHALL hold the FSM state enum typedef and the reset values of the key/auto synchronizers.
REQ-028 The two-flop synchronizer SHALL be one sub-module, sync_2ff, instantiated once per asynchronous input.

Verification (DEBOUNCE_CYCLES=4, AUTO_DIV=4)
REQ-029 Reset low 10 ns then high, key_n=1 -> step, pressed and step_count stay 0 for 50 cycles.
REQ-030 key_n low, held for 20 cycles -> one step pulse, high from edge 6 to edge 7 after first low sample; pressed=1; step_count=1.
REQ-031 key_n low 2 cycles, high 2, low 2 (bounce) -> no step; step_count unchanged.
REQ-032 Preset step_count=255 via 255 clean presses, then one more press -> step_count=0.
REQ-033 Macro defined, auto_mode=1 for 40 cycles -> 10 step pulses, exactly 4 cycles apart; a key press during this window adds no step.
REQ-034 resetn pulsed low while in S_DN_WAIT with key held -> outputs 0 at once; after release, exactly one step per REQ-017 timing.
